// File: rtl/reg_wb_pkg.sv
// Shared writeback-stage types; also imported by the register file and decoder.
package reg_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    LD_WB   = 2'd2
  } wb_state_t;

  localparam int PAR_REG = 6;

endpackage

// File: rtl/reg_wb_if.sv
// Core/memory/register-file bundle around the writeback stage.
interface reg_wb_if #(
  parameter int PW = 3,
  parameter int DW = 8,
  parameter int AW = 8
);
  // core-side requests
  logic          alu_we;
  logic [PW-1:0] alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          ld_req;
  logic [PW-1:0] ld_waddr;
  logic [AW-1:0] ld_maddr;
  logic          st_req;
  logic [AW-1:0] st_maddr;
  logic [DW-1:0] st_wdata;
  // data memory
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  // register file and core status
  logic          rf_wr_en;
  logic [PW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_dat_in;
  logic          par;
  logic          stall;
  logic          err;

  modport slave (
    input  alu_we, alu_waddr, alu_wdata,
    input  ld_req, ld_waddr, ld_maddr,
    input  st_req, st_maddr, st_wdata,
    input  mem_rd_data,
    output mem_addr, mem_wr_en, mem_wr_data,
    output rf_wr_en, rf_wr_addr, rf_dat_in, par, stall, err
  );

  modport master (
    output alu_we, alu_waddr, alu_wdata,
    output ld_req, ld_waddr, ld_maddr,
    output st_req, st_maddr, st_wdata,
    output mem_rd_data,
    input  mem_addr, mem_wr_en, mem_wr_data,
    input  rf_wr_en, rf_wr_addr, rf_dat_in, par, stall, err
  );

endinterface

// File: rtl/reg_wb_unit.sv
// Writeback / load-store stage: merges ALU and load writebacks into the register
// file, issues stores, owns the parity alias register and stalls for loads.
module reg_wb_unit
  import reg_wb_pkg::*;
#(
  parameter int PW      = 3,
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int PAR_REG = reg_wb_pkg::PAR_REG
) (
  input logic     clk,
  input logic     rst_n,
  reg_wb_if.slave bus
);

  localparam logic [PW-1:0] PAR_IDX = PW'(PAR_REG);

  wb_state_t     state_q, state_d;
  logic [PW-1:0] ld_waddr_q, ld_waddr_d;
  logic          rf_wr_en_q, rf_wr_en_d;
  logic [PW-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DW-1:0] rf_dat_in_q, rf_dat_in_d;
  logic          par_q, par_d;
  logic          err_q, err_d;

  // selected writeback for the next cycle, before the parity alias split
  logic          wb_go;
  logic [PW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          any_req;

  assign any_req = bus.alu_we | bus.ld_req | bus.st_req;

  always_comb begin
    state_d         = state_q;
    ld_waddr_d      = ld_waddr_q;
    rf_wr_en_d      = 1'b0;
    rf_wr_addr_d    = rf_wr_addr_q;
    rf_dat_in_d     = rf_dat_in_q;
    par_d           = par_q;
    err_d           = err_q;
    wb_go           = 1'b0;
    wb_addr         = '0;
    wb_data         = '0;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;

    case (state_q)
      IDLE: begin
        // a load wins over a simultaneous store; the store is dropped and flagged
        if (bus.ld_req) begin
          bus.mem_addr = bus.ld_maddr;
          ld_waddr_d   = bus.ld_waddr;
          state_d      = LD_WAIT;
          if (bus.st_req) err_d = 1'b1;
        end else if (bus.st_req) begin
          bus.mem_addr    = bus.st_maddr;
          bus.mem_wr_en   = 1'b1;
          bus.mem_wr_data = bus.st_wdata;
        end
        if (bus.alu_we) begin
          wb_go   = 1'b1;
          wb_addr = bus.alu_waddr;
          wb_data = bus.alu_wdata;
        end
      end
      LD_WAIT: begin
        wb_go   = 1'b1;
        wb_addr = ld_waddr_q;
        wb_data = bus.mem_rd_data;
        state_d = LD_WB;
        if (any_req) err_d = 1'b1;
      end
      LD_WB: begin
        state_d = IDLE;
        if (any_req) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // parity register is an alias: it never reaches the register file write port
    if (wb_go) begin
      if (wb_addr == PAR_IDX) begin
        par_d = wb_data[0];
      end else begin
        rf_wr_en_d   = 1'b1;
        rf_wr_addr_d = wb_addr;
        rf_dat_in_d  = wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ld_waddr_q   <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_dat_in_q  <= '0;
      par_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_waddr_q   <= ld_waddr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_dat_in_q  <= rf_dat_in_d;
      par_q        <= par_d;
      err_q        <= err_d;
    end
  end

  assign bus.stall      = (state_q != IDLE);
  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_wr_addr = rf_wr_addr_q;
  assign bus.rf_dat_in  = rf_dat_in_q;
  assign bus.par        = par_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_reg_wb_unit.sv
// Randomized bench for reg_wb_unit against a cycle-scheduled behavioural model.
module tb_reg_wb_unit;
  import reg_wb_pkg::*;

  localparam int PW = 3;
  localparam int DW = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_wb_if #(.PW(PW), .DW(DW), .AW(AW)) bus ();

  reg_wb_unit #(.PW(PW), .DW(DW), .AW(AW), .PAR_REG(PAR_REG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // synchronous-read data memory; writes are ignored while reset is held
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst_n && bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= mem[bus.mem_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model: expected memory, stall countdown, sticky flags, writes scheduled by cycle
  logic [7:0] mem_m [256];
  int         busy;
  bit         err_m, par_m;
  bit         rv [8];
  logic [2:0] ra [8];
  logic [7:0] rdat [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    busy  = 0;
    err_m = 0;
    par_m = 0;
    for (int i = 0; i < 8; i++) rv[i] = 0;
  endtask

  task automatic step(input bit aw, input logic [2:0] awa, input logic [7:0] awd,
                      input bit ld, input logic [2:0] lwa, input logic [7:0] lma,
                      input bit st, input logic [7:0] sma, input logic [7:0] swd);
    int s;
    bit exp_en;
    bus.alu_we = aw; bus.alu_waddr = awa; bus.alu_wdata = awd;
    bus.ld_req = ld; bus.ld_waddr = lwa;  bus.ld_maddr = lma;
    bus.st_req = st; bus.st_maddr = sma;  bus.st_wdata = swd;
    #1;
    s = cyc % 8;
    if (rv[s] && ra[s] == 3'(PAR_REG)) par_m = rdat[s][0];
    exp_en = rv[s] && (ra[s] != 3'(PAR_REG));
    chk("rf_wr_en", bus.rf_wr_en, exp_en);
    if (exp_en) begin
      chk("rf_wr_addr", bus.rf_wr_addr, ra[s]);
      chk("rf_dat_in", bus.rf_dat_in, rdat[s]);
    end
    rv[s] = 0;
    chk("par", bus.par, par_m);
    chk("err", bus.err, err_m);
    chk("stall", bus.stall, busy > 0);
    if (busy > 0) begin
      chk("mem_wr_en_stalled", bus.mem_wr_en, 0);
      busy--;
      if (aw || ld || st) err_m = 1;
    end else begin
      if (ld) begin
        chk("mem_addr_ld", bus.mem_addr, lma);
        chk("mem_wr_en_ld", bus.mem_wr_en, 0);
        rv[(cyc + 2) % 8] = 1; ra[(cyc + 2) % 8] = lwa; rdat[(cyc + 2) % 8] = mem_m[lma];
        busy = 2;
        if (st) err_m = 1;
      end else if (st) begin
        chk("mem_addr_st", bus.mem_addr, sma);
        chk("mem_wr_en_st", bus.mem_wr_en, 1);
        chk("mem_wr_data_st", bus.mem_wr_data, swd);
        mem_m[sma] = swd;
      end else begin
        chk("mem_wr_en_idle", bus.mem_wr_en, 0);
        chk("mem_addr_idle", bus.mem_addr, 0);
        chk("mem_wr_data_idle", bus.mem_wr_data, 0);
      end
      if (aw) begin
        rv[(cyc + 1) % 8] = 1; ra[(cyc + 1) % 8] = awa; rdat[(cyc + 1) % 8] = awd;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // asynchronous reset asserted mid-cycle with random inputs, held across one edge
  task automatic do_reset();
    rst_n = 1'b0;
    bus.alu_we = 1'($urandom); bus.alu_waddr = 3'($urandom); bus.alu_wdata = 8'($urandom);
    bus.ld_req = 1'($urandom); bus.ld_waddr = 3'($urandom);  bus.ld_maddr = 8'($urandom);
    bus.st_req = 1'($urandom); bus.st_maddr = 8'($urandom);  bus.st_wdata = 8'($urandom);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_rf_wr_en", bus.rf_wr_en, 0);
    chk("rst_par", bus.par, 0);
    chk("rst_err", bus.err, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_rf_wr_en", bus.rf_wr_en, 0);
    chk("rst_hold_stall", bus.stall, 0);
    rst_n = 1'b1;
    model_clear();
    cyc++;
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [7:0] d);
    mem[a]   = d;
    mem_m[a] = d;
  endtask

  initial begin
    bit polite;
    bit aw, ld, st;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'($urandom);
      mem_m[i] = mem[i];
    end
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // ALU write to reg 3
    step(1, 3, 8'hA5, 0, 0, 0, 0, 0, 0);
    chk("alu_dat_a5", bus.rf_dat_in, 8'hA5);
    idle();
    // load mem[10] -> reg 2
    set_mem(8'h10, 8'h3C);
    step(0, 0, 0, 1, 2, 8'h10, 0, 0, 0);
    idle();
    chk("ld_dat_3c", bus.rf_dat_in, 8'h3C);
    idle();
    idle();
    // store then load-back
    step(0, 0, 0, 0, 0, 0, 1, 8'h20, 8'h77);
    step(0, 0, 0, 1, 1, 8'h20, 0, 0, 0);
    idle();
    chk("ldback_dat_77", bus.rf_dat_in, 8'h77);
    idle();
    // parity alias via ALU and via load
    step(1, 6, 8'h01, 0, 0, 0, 0, 0, 0);
    chk("par_alu", bus.par, 1);
    set_mem(8'h30, 8'hFE);
    step(0, 0, 0, 1, 6, 8'h30, 0, 0, 0);
    idle();
    chk("par_ld", bus.par, 0);
    idle();
    // ld+st collision, then writes during stall
    step(0, 0, 0, 1, 4, 8'h40, 1, 8'h41, 8'h99);
    step(1, 5, 8'h11, 0, 0, 0, 0, 0, 0);
    step(1, 5, 8'h22, 0, 0, 0, 0, 0, 0);
    chk("err_sticky", bus.err, 1);
    idle();
    idle();
    do_reset();
    // reset during LD_WAIT drops the load
    step(0, 0, 0, 1, 1, 8'h50, 0, 0, 0);
    do_reset();
    idle();
    idle();

    // random traffic; polite phases avoid violations so err/par stay interesting
    polite = 1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        polite = ($urandom_range(0, 2) != 0);
      end else begin
        aw = ($urandom_range(0, 9) < 5);
        ld = ($urandom_range(0, 9) < 2);
        st = ($urandom_range(0, 9) < 2);
        if (polite && busy > 0) begin aw = 0; ld = 0; st = 0; end
        if (polite && ld) st = 0;
        step(aw, 3'($urandom), 8'($urandom), ld, 3'($urandom), 8'($urandom),
             st, 8'($urandom), 8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
